// File: rtl/alu_pkg.sv
// Shared definitions for the 64-bit execute-stage ALU.
package alu_pkg;

  localparam int unsigned DataWidth = 64;

  typedef logic [2:0] alu_op_t;

  localparam alu_op_t ALU_PASS_B   = 3'b000;
  localparam alu_op_t ALU_ADD      = 3'b010;
  localparam alu_op_t ALU_SUBTRACT = 3'b011;
  localparam alu_op_t ALU_AND      = 3'b100;
  localparam alu_op_t ALU_OR       = 3'b101;
  localparam alu_op_t ALU_XOR      = 3'b110;

endpackage

// File: rtl/alu_if.sv
// Operand/operation inputs and registered result/flag outputs of the ALU.
interface alu_if;
  import alu_pkg::*;

  logic [DataWidth-1:0] A;
  logic [DataWidth-1:0] B;
  alu_op_t              cntrl;
  logic [DataWidth-1:0] result;
  logic                 negative;
  logic                 zero;
  logic                 overflow;
  logic                 carry_out;

  modport master (
    output A, B, cntrl,
    input  result, negative, zero, overflow, carry_out
  );

  modport slave (
    input  A, B, cntrl,
    output result, negative, zero, overflow, carry_out
  );

endinterface

// File: rtl/alu_slice.sv
// One bit of the ALU: optional B inversion, full adder and logic-op select.
module alu_slice
  import alu_pkg::*;
(
  input  logic    a,
  input  logic    b,
  input  logic    carry_in,
  input  alu_op_t cntrl,
  output logic    out,
  output logic    carry_out
);

  logic b_eff;
  logic sum;

  // Subtract inverts B so the chain computes A + ~B + 1.
  always_comb begin
    b_eff     = (cntrl == ALU_SUBTRACT) ? ~b : b;
    sum       = a ^ b_eff ^ carry_in;
    carry_out = (a & b_eff) | (a & carry_in) | (b_eff & carry_in);
  end

  // Per-bit result select; unused codes yield 0.
  always_comb begin
    out = 1'b0;
    case (cntrl)
      ALU_PASS_B:            out = b;
      ALU_ADD, ALU_SUBTRACT: out = sum;
      ALU_AND:               out = a & b;
      ALU_OR:                out = a | b;
      ALU_XOR:               out = a ^ b;
      default:               out = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu.sv
// 64-bit ALU: ripple-carry slice array with a registered result/flag stage.
module alu
  import alu_pkg::*;
(
  input logic   clk,
  input logic   reset,
  alu_if.slave  bus
);

  logic [DataWidth:0]   carry;
  logic [DataWidth-1:0] comb_result;
  logic                 is_arith;
  logic                 comb_overflow;
  logic                 comb_carry;
  logic                 comb_zero;

  // Carry-in of 1 on subtract completes the two's-complement negation of B.
  always_comb begin
    is_arith = (bus.cntrl == ALU_ADD) || (bus.cntrl == ALU_SUBTRACT);
    carry[0] = (bus.cntrl == ALU_SUBTRACT) ? bus.cntrl[0] : 1'b0;
  end

  for (genvar i = 0; i < DataWidth; i++) begin : g_slice
    alu_slice u_slice (
      .a         (bus.A[i]),
      .b         (bus.B[i]),
      .carry_in  (carry[i]),
      .cntrl     (bus.cntrl),
      .out       (comb_result[i]),
      .carry_out (carry[i+1])
    );
  end

  // Signed overflow is a mismatch between carry into and out of the sign bit.
  always_comb begin
    comb_overflow = is_arith & (carry[DataWidth-1] ^ carry[DataWidth]);
    comb_carry    = is_arith & carry[DataWidth];
    comb_zero     = ~|comb_result;
  end

  // Output register; reset forces the all-zero result with zero flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.result    <= '0;
      bus.negative  <= 1'b0;
      bus.zero      <= 1'b1;
      bus.overflow  <= 1'b0;
      bus.carry_out <= 1'b0;
    end else begin
      bus.result    <= comb_result;
      bus.negative  <= comb_result[DataWidth-1];
      bus.zero      <= comb_zero;
      bus.overflow  <= comb_overflow;
      bus.carry_out <= comb_carry;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, corner sequences and
// randomized operations against an arithmetic reference model.
module tb_alu;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  alu_if u_if ();

  alu u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [2:0] OpPass = 3'b000;
  localparam logic [2:0] OpAdd  = 3'b010;
  localparam logic [2:0] OpSub  = 3'b011;
  localparam logic [2:0] OpAnd  = 3'b100;
  localparam logic [2:0] OpOr   = 3'b101;
  localparam logic [2:0] OpXor  = 3'b110;

  localparam logic [63:0] Ones = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] Max  = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] Min  = 64'h8000_0000_0000_0000;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    logic        n;
    logic        z;
    logic        v;
    logic        c;
  } vec_t;

  vec_t vecs[$];

  // Reference: signed results are checked against the representable range.
  task automatic model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                       output logic [63:0] r, output logic n, output logic z,
                       output logic v, output logic c);
    logic signed [64:0] smax;
    logic signed [64:0] smin;
    logic signed [64:0] s;
    logic [64:0]        u;
    smax = 65'sh0_7FFF_FFFF_FFFF_FFFF;
    smin = -65'sh0_8000_0000_0000_0000;
    r = '0;
    v = 1'b0;
    c = 1'b0;
    case (op)
      OpPass: r = b;
      OpAdd: begin
        u = {1'b0, a} + {1'b0, b};
        r = u[63:0];
        c = (u >= 65'h1_0000_0000_0000_0000);
        s = $signed({a[63], a}) + $signed({b[63], b});
        v = (s > smax) || (s < smin);
      end
      OpSub: begin
        r = a - b;
        c = (a >= b);
        s = $signed({a[63], a}) - $signed({b[63], b});
        v = (s > smax) || (s < smin);
      end
      OpAnd: r = a & b;
      OpOr:  r = a | b;
      OpXor: r = a ^ b;
      default: r = '0;
    endcase
    n = (r >= Min);
    z = (r == 0);
  endtask

  task automatic check_out(input string tag, input logic [63:0] r, input logic n,
                           input logic z, input logic v, input logic c);
    checks++;
    if (u_if.result !== r || u_if.negative !== n || u_if.zero !== z ||
        u_if.overflow !== v || u_if.carry_out !== c) begin
      failures++;
      $display("FAIL %s: got result=%h n=%b z=%b v=%b c=%b, expected result=%h n=%b z=%b v=%b c=%b",
               tag, u_if.result, u_if.negative, u_if.zero, u_if.overflow, u_if.carry_out,
               r, n, z, v, c);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    u_if.cntrl = op;
    u_if.A     = a;
    u_if.B     = b;
  endtask

  // Drive, let one edge capture, then check 1 time unit after the edge.
  task automatic run_model(input string tag, input logic [2:0] op, input logic [63:0] a,
                           input logic [63:0] b);
    logic [63:0] r;
    logic        n, z, v, c;
    model(op, a, b, r, n, z, v, c);
    drive(op, a, b);
    @(posedge clk);
    #1;
    check_out(tag, r, n, z, v, c);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    logic [63:0] r;
    logic        n, z, v, c;
    logic [2:0]  op;
    checks   = 0;
    failures = 0;

    vecs.push_back('{"add_1_1",      OpAdd,  64'h1,  64'h1, 64'h2,                  0, 0, 0, 0});
    vecs.push_back('{"add_max_max",  OpAdd,  Max,    Max,   64'hFFFF_FFFF_FFFF_FFFE, 1, 0, 1, 0});
    vecs.push_back('{"add_wrap",     OpAdd,  Ones,   64'h1, 64'h0,                  0, 1, 0, 1});
    vecs.push_back('{"sub_max_min",  OpSub,  Max,    Min,   Ones,                   1, 0, 1, 0});
    vecs.push_back('{"sub_5_5",      OpSub,  64'h5,  64'h5, 64'h0,                  0, 1, 0, 1});
    vecs.push_back('{"sub_0_1",      OpSub,  64'h0,  64'h1, Ones,                   1, 0, 0, 0});
    vecs.push_back('{"sub_min_1",    OpSub,  Min,    64'h1, Max,                    0, 0, 1, 1});
    vecs.push_back('{"and_max_min",  OpAnd,  Max,    Min,   64'h0,                  0, 1, 0, 0});
    vecs.push_back('{"or_ones",      OpOr,   Ones,   Ones,  Ones,                   1, 0, 0, 0});
    vecs.push_back('{"xor_ones",     OpXor,  Ones,   Ones,  64'h0,                  0, 1, 0, 0});
    vecs.push_back('{"pass_zero",    OpPass, Ones,   64'h0, 64'h0,                  0, 1, 0, 0});
    vecs.push_back('{"pass_min",     OpPass, 64'h0,  Min,   Min,                    1, 0, 0, 0});
    vecs.push_back('{"unused_001",   3'b001, Ones,   Ones,  64'h0,                  0, 1, 0, 0});
    vecs.push_back('{"unused_111",   3'b111, Ones,   Ones,  64'h0,                  0, 1, 0, 0});

    // Reset with an ADD of all-ones pending: reset must win.
    reset = 1'b1;
    drive(OpAdd, Ones, Ones);
    @(posedge clk);
    #1;
    check_out("reset", 64'h0, 0, 1, 0, 0);

    // First edge after reset captures the inputs already present.
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_out("post_reset_capture", 64'hFFFF_FFFF_FFFF_FFFE, 1, 0, 0, 1);

    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b);
      @(posedge clk);
      #1;
      check_out(vecs[i].name, vecs[i].res, vecs[i].n, vecs[i].z, vecs[i].v, vecs[i].c);
    end

    // Inputs changed between edges must not reach the outputs early.
    run_model("hold_setup", OpAdd, 64'h10, 64'h20);
    drive(OpXor, Ones, 64'h1234);
    #3;
    check_out("hold_between_edges", 64'h30, 0, 0, 0, 0);

    // Reset mid-stream discards the in-flight operation.
    drive(OpOr, Ones, 64'h0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_out("reset_midstream", 64'h0, 0, 1, 0, 0);
    reset = 1'b0;

    for (int i = 0; i < 100; i++) run_model("rand_pass", OpPass, rnd64(), rnd64());
    for (int i = 0; i < 100; i++) run_model("rand_add", OpAdd, rnd64(), rnd64());
    for (int i = 0; i < 100; i++) run_model("rand_sub", OpSub, rnd64(), rnd64());
    for (int i = 0; i < 100; i++) run_model("rand_and", OpAnd, rnd64(), rnd64());
    for (int i = 0; i < 100; i++) run_model("rand_or", OpOr, rnd64(), rnd64());
    for (int i = 0; i < 100; i++) run_model("rand_xor", OpXor, rnd64(), rnd64());

    // Signed-boundary operands stress overflow and carry on add/subtract.
    for (int i = 0; i < 50; i++) begin
      op = ($urandom_range(0, 1) == 0) ? OpAdd : OpSub;
      run_model("rand_boundary", op, Min + 64'($urandom_range(0, 3)) - 64'h2,
                Min + 64'($urandom_range(0, 3)) - 64'h2);
    end

    // Back-to-back: a new random code, including unused ones, every cycle.
    for (int i = 0; i < 200; i++) begin
      op = 3'($urandom_range(0, 7));
      run_model("back_to_back", op, rnd64(), rnd64());
    end

    // Random PASS_B of zero keeps the zero flag honest.
    model(OpPass, rnd64(), 64'h0, r, n, z, v, c);
    run_model("pass_b_zero_rand", OpPass, rnd64(), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
